// File: rtl/mmio_regbank.sv
// mmio_regbank: CPU-facing register bank front end.
//   Accepts CPU accesses on a req/ack handshake, answers reads at once (live core value or
//   open-bus), and queues every access so it can be replayed to the core as a one-cycle
//   read/write strobe on the next `tick`.
// Ports:
//   clk, reset (sync, active-high), tick (core clock enable)
//   memaddr/memwdata/memwr/memreq -> CPU request; memack/memrdata <- one-cycle response
//   rdsrc    : live read values from the core, field i = address i
//   regwdata/wrstb/rdstb/wphase : replayed strobe towards the core
//   shadow   : locally held shadow registers (non-shadowed fields read 0)
//   qfull    : pending-access queue full
module mmio_regbank #(
  parameter int unsigned         AW         = 3,
  parameter int unsigned         DW         = 8,
  parameter int unsigned         DEPTH      = 2,
  parameter logic [2**AW-1:0]    LATCHMASK  = 8'b0110_0000,
  parameter int unsigned         CLRADDR    = 2,
  parameter logic [2**AW-1:0]    RDMASK     = 8'b1001_0100,
  parameter logic [2**AW-1:0]    SHADOWMASK = 8'b0000_0011
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [AW-1:0]          memaddr,
  input  logic [DW-1:0]          memwdata,
  input  logic                   memwr,
  input  logic                   memreq,
  output logic                   memack,
  output logic [DW-1:0]          memrdata,
  input  logic [(2**AW)*DW-1:0]  rdsrc,
  output logic [DW-1:0]          regwdata,
  output logic [2**AW-1:0]       wrstb,
  output logic [2**AW-1:0]       rdstb,
  output logic                   wphase,
  output logic [(2**AW)*DW-1:0]  shadow,
  output logic                   qfull
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ph;
  } entry_t;

  entry_t              fifo_q [DEPTH];
  entry_t              fifo_d [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                memreq0_q, pend_q, pend_d, w_q, w_d;
  logic [DW-1:0]       obus_q, obus_d;
  logic                memack_q, memack_d;
  logic [DW-1:0]       memrdata_q, memrdata_d;
  logic [DW-1:0]       regwdata_q, regwdata_d;
  logic [NREG-1:0]     wrstb_q, wrstb_d, rdstb_q, rdstb_d;
  logic                wphase_q, wphase_d;
  logic [NREG*DW-1:0]  shadow_q, shadow_d;

  logic    req_edge, full, pop, accept;
  logic [DW-1:0] rd_live;
  entry_t  push_e, head_e;

  always_comb begin
    req_edge = memreq & ~memreq0_q;
    full     = (cnt_q == CW'(DEPTH));
    pop      = tick & (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    accept   = (pend_q | req_edge) & (~full | pop);

    rd_live = obus_q;
    for (int i = 0; i < NREG; i++) begin
      if (memaddr == AW'(i) && RDMASK[i]) rd_live = rdsrc[i*DW +: DW];
    end

    push_e.wr   = memwr;
    push_e.addr = memaddr;
    push_e.data = memwdata;
    push_e.ph   = memwr & LATCHMASK[memaddr] & w_q;
    head_e      = fifo_q[rptr_q];

    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pend_d     = pend_q;
    w_d        = w_q;
    obus_d     = obus_q;
    memack_d   = accept;
    memrdata_d = memrdata_q;
    regwdata_d = regwdata_q;
    wphase_d   = wphase_q;
    wrstb_d    = '0;
    rdstb_d    = '0;

    if (accept) begin
      pend_d         = 1'b0;
      fifo_d[wptr_q] = push_e;
      wptr_d         = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (memwr) begin
        obus_d = memwdata;
        if (LATCHMASK[memaddr]) w_d = ~w_q;
      end else begin
        memrdata_d = rd_live;
        obus_d     = rd_live;
        if (memaddr == AW'(CLRADDR)) w_d = 1'b0;
      end
    end else if (req_edge) begin
      pend_d = 1'b1;
    end

    if (pop) begin
      rptr_d     = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      regwdata_d = head_e.data;
      wphase_d   = head_e.ph;
      if (head_e.wr) wrstb_d[head_e.addr] = 1'b1;
      else           rdstb_d[head_e.addr] = 1'b1;
    end

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Shadow captures the data of the strobe currently presented to the core.
    shadow_d = shadow_q;
    for (int i = 0; i < NREG; i++) begin
      if (!SHADOWMASK[i])                shadow_d[i*DW +: DW] = '0;
      else if (wrstb_q[i]) shadow_d[i*DW +: DW] = regwdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      memreq0_q  <= 1'b0;
      pend_q     <= 1'b0;
      w_q        <= 1'b0;
      obus_q     <= '0;
      memack_q   <= 1'b0;
      memrdata_q <= '0;
      regwdata_q <= '0;
      wrstb_q    <= '0;
      rdstb_q    <= '0;
      wphase_q   <= 1'b0;
      shadow_q   <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      memreq0_q  <= memreq;
      pend_q     <= pend_d;
      w_q        <= w_d;
      obus_q     <= obus_d;
      memack_q   <= memack_d;
      memrdata_q <= memrdata_d;
      regwdata_q <= regwdata_d;
      wrstb_q    <= wrstb_d;
      rdstb_q    <= rdstb_d;
      wphase_q   <= wphase_d;
      shadow_q   <= shadow_d;
    end
  end

  assign memack   = memack_q;
  assign memrdata = memrdata_q;
  assign regwdata = regwdata_q;
  assign wrstb    = wrstb_q;
  assign rdstb    = rdstb_q;
  assign wphase   = wphase_q;
  assign shadow   = shadow_q;
  assign qfull    = full;

endmodule

// File: tb/tb_mmio_regbank.sv
// Directed bench for mmio_regbank with default parameters (AW=3, DW=8, DEPTH=2).
module tb_mmio_regbank;

  logic        clk, reset, tick;
  logic [2:0]  memaddr;
  logic [7:0]  memwdata;
  logic        memwr, memreq;
  logic        memack;
  logic [7:0]  memrdata;
  logic [63:0] rdsrc;
  logic [7:0]  regwdata;
  logic [7:0]  wrstb, rdstb;
  logic        wphase;
  logic [63:0] shadow;
  logic        qfull;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_regbank dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .memaddr  (memaddr),
    .memwdata (memwdata),
    .memwr    (memwr),
    .memreq   (memreq),
    .memack   (memack),
    .memrdata (memrdata),
    .rdsrc    (rdsrc),
    .regwdata (regwdata),
    .wrstb    (wrstb),
    .rdstb    (rdstb),
    .wphase   (wphase),
    .shadow   (shadow),
    .qfull    (qfull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [2:0] a, input logic [7:0] d);
    memwr = 1'b1; memaddr = a; memwdata = d; memreq = 1'b1;
    step();
    check_eq({tag, " ack"}, 64'(memack), 64'd1);
    memreq = 1'b0;
    step();
    check_eq({tag, " ack low"}, 64'(memack), 64'd0);
  endtask

  task automatic do_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
    memwr = 1'b0; memaddr = a; memreq = 1'b1;
    step();
    check_eq({tag, " ack"}, 64'(memack), 64'd1);
    check_eq({tag, " rdata"}, 64'(memrdata), 64'(exp));
    memreq = 1'b0;
    step();
  endtask

  // One tick, then check the strobe it produces and that it lasts one cycle.
  task automatic pop_chk(input string tag, input bit wr, input int a, input logic [7:0] d,
                         input bit ph);
    logic [7:0] one;
    one  = 8'd1 << a;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq({tag, " wrstb"}, 64'(wrstb), wr ? 64'(one) : 64'd0);
    check_eq({tag, " rdstb"}, 64'(rdstb), wr ? 64'd0 : 64'(one));
    if (wr) begin
      check_eq({tag, " regwdata"}, 64'(regwdata), 64'(d));
      check_eq({tag, " wphase"}, 64'(wphase), 64'(ph));
    end
    step();
    check_eq({tag, " strobe end"}, 64'(wrstb | rdstb), 64'd0);
  endtask

  initial begin
    int acks, stbs;
    reset = 1'b1; tick = 1'b0; memaddr = '0; memwdata = '0; memwr = 1'b0; memreq = 1'b0;
    rdsrc = '0;
    step(); step();
    reset = 1'b0;
    check_eq("rst memack", 64'(memack), 64'd0);
    check_eq("rst strobes", 64'(wrstb | rdstb), 64'd0);
    check_eq("rst shadow", shadow, 64'd0);
    check_eq("rst qfull", 64'(qfull), 64'd0);
    check_eq("rst memrdata", 64'(memrdata), 64'd0);

    // Single write to shadowed address 0.
    do_write("w0", 3'd0, 8'h5A);
    pop_chk("w0 pop", 1'b1, 0, 8'h5A, 1'b0);
    check_eq("w0 shadow", shadow, 64'h5A);

    // Latch phase sequence and clear-on-read.
    do_write("w5a", 3'd5, 8'h11);
    pop_chk("w5a pop", 1'b1, 5, 8'h11, 1'b0);
    do_write("w5b", 3'd5, 8'h22);
    pop_chk("w5b pop", 1'b1, 5, 8'h22, 1'b1);
    do_write("w6a", 3'd6, 8'h33);
    pop_chk("w6a pop", 1'b1, 6, 8'h33, 1'b0);
    rdsrc[2*8 +: 8] = 8'h77;
    do_read("r2", 3'd2, 8'h77);
    pop_chk("r2 pop", 1'b0, 2, 8'h00, 1'b0);
    do_write("w6b", 3'd6, 8'h44);
    pop_chk("w6b pop", 1'b1, 6, 8'h44, 1'b0);

    // Live read then open-bus read, replayed in order.
    rdsrc[7*8 +: 8] = 8'hC3;
    do_read("r7", 3'd7, 8'hC3);
    do_read("r1 obus", 3'd1, 8'hC3);
    pop_chk("r7 pop", 1'b0, 7, 8'h00, 1'b0);
    pop_chk("r1 pop", 1'b0, 1, 8'h00, 1'b0);

    // Stall on full queue, accepted together with the freeing pop.
    do_write("f1", 3'd3, 8'hA3);
    do_write("f2", 3'd4, 8'hA4);
    check_eq("full qfull", 64'(qfull), 64'd1);
    memwr = 1'b1; memaddr = 3'd0; memwdata = 8'h99; memreq = 1'b1;
    step();
    check_eq("stall ack0", 64'(memack), 64'd0);
    memreq = 1'b0;
    step();
    check_eq("stall ack1", 64'(memack), 64'd0);
    check_eq("stall qfull", 64'(qfull), 64'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("stall late ack", 64'(memack), 64'd1);
    check_eq("stall f1 wrstb", 64'(wrstb), 64'h08);
    check_eq("stall f1 data", 64'(regwdata), 64'hA3);
    check_eq("stall push+pop qfull", 64'(qfull), 64'd1);
    step();
    check_eq("stall ack once", 64'(memack), 64'd0);
    pop_chk("f2 pop", 1'b1, 4, 8'hA4, 1'b0);
    check_eq("f2 qfull", 64'(qfull), 64'd0);
    pop_chk("f3 pop", 1'b1, 0, 8'h99, 1'b0);
    check_eq("f3 shadow", shadow, 64'h99);

    // Reset with queued writes and a pending request.
    do_write("q1", 3'd5, 8'h55);
    do_write("q2", 3'd1, 8'h66);
    memwr = 1'b1; memaddr = 3'd0; memwdata = 8'hEE; memreq = 1'b1;
    step();
    memreq = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post-rst ack", 64'(memack), 64'd0);
      check_eq("post-rst strobes", 64'(wrstb | rdstb), 64'd0);
    end
    tick = 1'b0;
    check_eq("post-rst shadow", shadow, 64'd0);
    check_eq("post-rst qfull", 64'(qfull), 64'd0);
    do_write("w5 after rst", 3'd5, 8'h12);
    pop_chk("w5 after rst pop", 1'b1, 5, 8'h12, 1'b0);

    // Held request yields one access only.
    acks = 0; stbs = 0;
    memwr = 1'b1; memaddr = 3'd3; memwdata = 8'h3C; memreq = 1'b1; tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (memack) acks++;
      if (wrstb != 8'h00) stbs++;
    end
    memreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (memack) acks++;
      if (wrstb != 8'h00) stbs++;
    end
    tick = 1'b0;
    check_eq("held acks", 64'(acks), 64'd1);
    check_eq("held strobes", 64'(stbs), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_regbank.md
Name: mmio_regbank

Overview:
- Parametrised CPU-facing register bank that generalises the PPU register front end to N addresses and configurable per-address behaviour.
- Accepts CPU read/write requests on a req/ack handshake and returns read data immediately.
- Queues accesses in order and replays them as one-cycle read/write strobes aligned to the core's `tick` enable.
- Used in front of PPU, APU and mapper cores.

Parameters:
- AW, 3: address width; NREG = 2**AW registers.
- DW, 8: data width.
- DEPTH, 2: pending-access queue depth (>=1, power of two).
- LATCHMASK, 8'b0110_0000: addresses that share the two-phase write latch.
- CLRADDR, 2: a read of this address clears the write latch.
- RDMASK, 8'b1001_0100: addresses whose read data comes from `rdsrc`; all others return open-bus.
- SHADOWMASK, 8'b0000_0011: addresses with a locally held shadow register.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- tick, in, 1: core clock enable.
- memaddr, in, AW: CPU register address.
- memwdata, in, DW: CPU write data.
- memwr, in, 1: 1 = write, 0 = read.
- memreq, in, 1: request level; rising edge starts an access.
- memack, out, 1: one-cycle acknowledge.
- memrdata, out, DW: read data, valid while memack=1.
- rdsrc, in, NREG*DW: live read values from the core, field i = address i.
- regwdata, out, DW: data of the current write strobe.
- wrstb, out, NREG: one-hot write strobe.
- rdstb, out, NREG: one-hot read-side-effect strobe.
- wphase, out, 1: latch phase of the current write strobe (0 = first, 1 = second).
- shadow, out, NREG*DW: shadow register contents; fields not in SHADOWMASK read as 0.
- qfull, out, 1: queue full (debug/status).

Behaviour:
- Reset: clears queue and pointers, the pending-edge flag, latch phase `w`, open-bus register `obus`, all shadows, memack, memrdata, wrstb, rdstb, regwdata and wphase. A request in flight is dropped and no ack is issued. A rising edge on memreq at the first cycle after reset is detected normally, because `memreq0` resets to 0.
- Edge detect:
  - `memreq0 <= memreq` every clk.
  - `memreq && !memreq0` sets the `pend` flag.
  - Acceptance happens in any cycle with (`pend` or new edge) and queue not full.
- Accept cycle:
  - Push {wr, addr, wdata, ph} onto the queue.
  - Clear `pend`.
  - memack=1 on the next clk for exactly one cycle. Latency is 1 clk when not stalled.
- Write accept:
  - `obus <= memwdata`.
  - If addr is in LATCHMASK: ph = w, then `w <= !w`; otherwise ph = 0.
- Read accept:
  - Data = rdsrc[addr] if addr is in RDMASK, else obus.
  - `memrdata <= data` and `obus <= data`.
  - If addr == CLRADDR then `w <= 0`; this takes effect for the next accepted write.
- Stall: if the queue is full, the request waits in `pend` with memack held low. It is accepted in the first cycle with free space, including a cycle where a pop frees space.
- Pop and strobes:
  - In a clk where tick=1 and the queue is non-empty, the head is popped.
  - On the next clk exactly one strobe bit is asserted for one cycle: wrstb[addr] for a write, rdstb[addr] for a read.
  - regwdata = entry data and wphase = entry ph for that cycle.
  - At most one pop per tick. Strobes are 0 otherwise.
- Shadow update: on a write strobe to an address in SHADOWMASK, that shadow field takes regwdata in the same cycle as the strobe, so it is visible on the following clk.
- Simultaneous push and pop in one cycle: both occur and the count is unchanged. A full queue with a pop in the same cycle accepts the pending request.
- Pointers wrap modulo DEPTH. Ordering is strict FIFO.
- memreq held high produces no repeat access. Falling edges are ignored.

Test Plan:
- Write 0x5A to addr 0, tick every 4 clk → memack exactly 1 clk after the edge; wrstb[0]=1 for 1 cycle after the next tick; regwdata=0x5A; shadow[0]=0x5A; wphase=0.
- Writes 0x11 then 0x22 to addr 5, then 0x33 to addr 6 → strobes in order with wphase 0, 1, 0. Then read addr 2 followed by a write to 6 → that write has wphase 0.
- Read addr 7 with rdsrc[7]=0xC3 → memrdata=0xC3 with memack. A following read of addr 1 (not in RDMASK) returns 0xC3 (open-bus); rdstb[1] pulses after a tick.
- tick held 0 while 3 writes (DEPTH=2) are issued → first two acked; third ack withheld and qfull=1. Raise tick → third acked in the cycle after the pop; all three strobes emerge in order.
- reset asserted with 2 queued writes and pend set → no strobes or ack afterwards; shadow=0, w=0. Next write to addr 5 has wphase 0.
- memreq held high for 10 clk → exactly one ack and one strobe.
